bus_arbiter_8x1: RTL and testbench

Round-robin arbiter that shares one 32-bit bus among 8 requesters and drives the select of an 8:1 32-bit word mux. It issues one-hot grants, steers the selected requester's word onto Y, and bounds each tenure with a burst cap. It sits in front of any shared datapath consumer (ALU operand bus, memory write port) where several sources compete.

---
 rtl/bus_arbiter_8x1_pkg.sv | 40 ++++
 rtl/bus_arbiter_8x1_mux.sv | 31 +++
 rtl/bus_arbiter_8x1.sv | 162 ++++++++++++++++
 tb/tb_bus_arbiter_8x1.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_8x1_pkg.sv
// Shared definitions for the 8-requester round-robin bus arbiter:
// requester count, select width, FSM state encoding and the rotating pick.
package bus_arbiter_8x1_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Result of one arbitration: whether anyone asked, and who won.
    typedef struct packed {
        logic             valid;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // Round-robin pick: the first set bit of req searching upward from ptr,
    // wrapping from N_REQ-1 to 0. The request vector is rotated so that ptr
    // lands on bit 0; a priority encode then gives the offset from ptr.
    function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                      input logic [SEL_W-1:0] ptr);
        logic [2*N_REQ-1:0] dbl;
        logic [N_REQ-1:0]   rot;
        pick_t              res;
        dbl       = {req, req} >> ptr;
        rot       = dbl[N_REQ-1:0];
        res.valid = |req;
        res.idx   = '0;
        // Scan from the top down so the lowest rotated offset wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                res.idx = ptr + SEL_W'(k);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bus_arbiter_8x1_mux.sv
// Plain 8:1 mux of 32-bit words; purely combinational, no gating.
module MUX32_8x1
    import bus_arbiter_8x1_pkg::*;
(
    input  logic [31:0]      i_d0,
    input  logic [31:0]      i_d1,
    input  logic [31:0]      i_d2,
    input  logic [31:0]      i_d3,
    input  logic [31:0]      i_d4,
    input  logic [31:0]      i_d5,
    input  logic [31:0]      i_d6,
    input  logic [31:0]      i_d7,
    input  logic [SEL_W-1:0] i_sel,
    output logic [31:0]      o_y
);

    // Steer the selected word to the output.
    always_comb begin
        case (i_sel)
            3'd0:    o_y = i_d0;
            3'd1:    o_y = i_d1;
            3'd2:    o_y = i_d2;
            3'd3:    o_y = i_d3;
            3'd4:    o_y = i_d4;
            3'd5:    o_y = i_d5;
            3'd6:    o_y = i_d6;
            default: o_y = i_d7;
        endcase
    end

endmodule

// File: rtl/bus_arbiter_8x1.sv
// Round-robin arbiter sharing one 32-bit bus among 8 requesters. Grants are
// registered one-hot, tenures are capped at HOLD_MAX beats, and the owner's
// word is steered onto Y through MUX32_8x1 with VALID gating applied here.
module bus_arbiter_8x1
    import bus_arbiter_8x1_pkg::*;
#(
    parameter int HOLD_MAX   = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [N_REQ-1:0]      REQ,
    input  logic [N_REQ-1:0]      LAST,
    input  logic [DATA_WIDTH-1:0] I0,
    input  logic [DATA_WIDTH-1:0] I1,
    input  logic [DATA_WIDTH-1:0] I2,
    input  logic [DATA_WIDTH-1:0] I3,
    input  logic [DATA_WIDTH-1:0] I4,
    input  logic [DATA_WIDTH-1:0] I5,
    input  logic [DATA_WIDTH-1:0] I6,
    input  logic [DATA_WIDTH-1:0] I7,
    output logic [N_REQ-1:0]      GNT,
    output logic [SEL_W-1:0]      SEL,
    output logic                  VALID,
    output logic [DATA_WIDTH-1:0] Y,
    output logic                  BUSY
);

    // Beat count at which the current tenure has used its last allowed beat.
    localparam logic [7:0] CAP_BEAT = 8'(HOLD_MAX - 1);

    state_t           r_state, w_state_next;
    logic [N_REQ-1:0] r_gnt,   w_gnt_next;
    logic [SEL_W-1:0] r_sel,   w_sel_next;
    logic [SEL_W-1:0] r_ptr,   w_ptr_next;
    logic [7:0]       r_cnt,   w_cnt_next;
    logic             r_valid, w_valid_next;
    logic             r_busy,  w_busy_next;

    logic             w_own_req;
    logic             w_own_last;
    logic             w_at_cap;
    logic             w_release;
    logic             w_cap_only;
    logic [N_REQ-1:0] w_arb_req;
    logic [SEL_W-1:0] w_arb_ptr;
    pick_t            w_pick;
    logic [31:0]      w_mux_y;

    // Decide whether the current owner gives up the bus at this edge, and
    // form the request set / start pointer for the arbitration that follows.
    always_comb begin
        w_own_req  = REQ[r_sel];
        w_own_last = LAST[r_sel];
        w_at_cap   = (r_cnt == CAP_BEAT);
        w_release  = !w_own_req || w_own_last || w_at_cap;
        // Only a cap-forced release lets the owner compete again.
        w_cap_only = w_at_cap && w_own_req && !w_own_last;
        if (r_state == ST_GRANT) begin
            w_arb_ptr = r_sel + 1'b1;
            w_arb_req = w_cap_only ? REQ : (REQ & ~(N_REQ'(1) << r_sel));
        end else begin
            w_arb_ptr = r_ptr;
            w_arb_req = REQ;
        end
        w_pick = rr_pick(w_arb_req, w_arb_ptr);
    end

    // Next-state and registered-output logic for the IDLE/GRANT FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        w_state_next = r_state;
        w_gnt_next   = r_gnt;
        w_sel_next   = r_sel;
        w_ptr_next   = r_ptr;
        w_cnt_next   = r_cnt;
        w_valid_next = r_valid;
        w_busy_next  = r_busy;
        case (r_state)
            ST_IDLE: begin
                if (w_pick.valid) begin
                    w_state_next = ST_GRANT;
                    w_gnt_next   = N_REQ'(1) << w_pick.idx;
                    w_sel_next   = w_pick.idx;
                    w_cnt_next   = '0;
                    w_valid_next = 1'b1;
                    w_busy_next  = 1'b1;
                end else begin
                    w_gnt_next   = '0;
                    w_valid_next = 1'b0;
                    w_busy_next  = 1'b0;
                end
            end
            ST_GRANT: begin
                if (!w_release) begin
                    w_cnt_next = r_cnt + 8'd1;
                end else begin
                    w_ptr_next = w_arb_ptr;
                    w_cnt_next = '0;
                    if (w_pick.valid) begin
                        w_gnt_next = N_REQ'(1) << w_pick.idx;
                        w_sel_next = w_pick.idx;
                    end else begin
                        w_state_next = ST_IDLE;
                        w_gnt_next   = '0;
                        w_valid_next = 1'b0;
                        w_busy_next  = 1'b0;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_gnt_next   = '0;
                w_valid_next = 1'b0;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset that drops any tenure in flight.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (RST) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_gnt   <= w_gnt_next;
            r_sel   <= w_sel_next;
            r_ptr   <= w_ptr_next;
            r_cnt   <= w_cnt_next;
            r_valid <= w_valid_next;
            r_busy  <= w_busy_next;
        end
    end

    MUX32_8x1 u_mux (
        .i_d0  (I0),
        .i_d1  (I1),
        .i_d2  (I2),
        .i_d3  (I3),
        .i_d4  (I4),
        .i_d5  (I5),
        .i_d6  (I6),
        .i_d7  (I7),
        .i_sel (r_sel),
        .o_y   (w_mux_y)
    );

    assign GNT   = r_gnt;
    assign SEL   = r_sel;
    assign VALID = r_valid;
    assign BUSY  = r_busy;
    // SEL holds its last value while idle, so the word must be gated off.
    assign Y     = r_valid ? w_mux_y : '0;

endmodule

// File: tb/tb_bus_arbiter_8x1.sv
// Bench for bus_arbiter_8x1: directed scenarios plus random traffic, each
// edge scored against a tenure-level reference model via an expected queue.
module tb_bus_arbiter_8x1;

    localparam int HOLD = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  REQ;
    logic [7:0]  LAST;
    logic [31:0] data [8];
    logic [7:0]  GNT;
    logic [2:0]  SEL;
    logic        VALID;
    logic        BUSY;
    logic [31:0] Y;

    bus_arbiter_8x1 #(.HOLD_MAX(HOLD), .DATA_WIDTH(32)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .REQ   (REQ),
        .LAST  (LAST),
        .I0    (data[0]),
        .I1    (data[1]),
        .I2    (data[2]),
        .I3    (data[3]),
        .I4    (data[4]),
        .I5    (data[5]),
        .I6    (data[6]),
        .I7    (data[7]),
        .GNT   (GNT),
        .SEL   (SEL),
        .VALID (VALID),
        .Y     (Y),
        .BUSY  (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       valid;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Reference model: who owns the bus, how many beats it has had, the
    // rotating priority start and the last select shown on SEL.
    int m_owner = -1;
    int m_beats = 0;
    int m_ptr   = 0;
    int m_sel   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic int rr_search(input logic [7:0] req, input int from);
        for (int k = 0; k < 8; k++) begin
            if (req[(from + k) % 8]) return (from + k) % 8;
        end
        return -1;
    endfunction

    // Advance the model by one edge using the inputs the DUT just sampled.
    task automatic model_step();
        exp_t e;
        if (RST) begin
            m_owner = -1;
            m_beats = 0;
            m_ptr   = 0;
            m_sel   = 0;
        end else if (m_owner < 0) begin
            int w;
            w = rr_search(REQ, m_ptr);
            if (w >= 0) begin
                m_owner = w;
                m_sel   = w;
                m_beats = 1;
            end
        end else begin
            bit keeps, fin, cap;
            keeps = REQ[m_owner];
            fin   = LAST[m_owner];
            cap   = (m_beats == HOLD);
            if (keeps && !fin && !cap) begin
                m_beats++;
            end else begin
                logic [7:0] cand;
                int w;
                cand = REQ;
                if (!(keeps && !fin)) cand[m_owner] = 1'b0;
                m_ptr = (m_owner + 1) % 8;
                w = rr_search(cand, m_ptr);
                if (w >= 0) begin
                    m_owner = w;
                    m_sel   = w;
                    m_beats = 1;
                end else begin
                    m_owner = -1;
                end
            end
        end
        e.gnt   = (m_owner >= 0) ? (8'b1 << m_owner) : 8'h00;
        e.sel   = 3'(m_sel);
        e.valid = (m_owner >= 0);
        e.busy  = (m_owner >= 0);
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic rst, input logic [7:0] req, input logic [7:0] last);
        RST  = rst;
        REQ  = req;
        LAST = last;
        @(posedge CLK);
        model_step();
        #1;
    endtask

    // Monitor: every falling edge, score the outputs against the oldest expectation.
    initial begin
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("gnt",   32'(GNT),   32'(e.gnt));
                check("sel",   32'(SEL),   32'(e.sel));
                check("valid", 32'(VALID), 32'(e.valid));
                check("busy",  32'(BUSY),  32'(e.busy));
                check("y",     Y,          e.valid ? data[e.sel] : 32'd0);
            end
        end
    end

    initial begin
        RST  = 1'b1;
        REQ  = 8'h00;
        LAST = 8'h00;
        for (int k = 0; k < 8; k++) data[k] = 32'd1431655700 + 32'(k);

        // Reset held with everyone requesting, then release.
        cycle(1'b1, 8'hFF, 8'h00);
        cycle(1'b1, 8'hFF, 8'h00);
        check("rst_gnt",   32'(GNT),   32'h0);
        check("rst_valid", 32'(VALID), 32'h0);
        check("rst_busy",  32'(BUSY),  32'h0);
        check("rst_y",     Y,          32'd0);
        cycle(1'b0, 8'hFF, 8'h00);
        check("first_gnt", 32'(GNT), 32'h01);
        check("first_y",   Y,        32'd1431655700);

        // Two requesters alternating at the burst cap.
        for (int i = 0; i < 13; i++) cycle(1'b0, 8'h24, 8'h00);

        // Sole requester 7 across the cap, then requester 0 joins.
        for (int i = 0; i < 10; i++) cycle(1'b0, 8'h80, 8'h00);
        for (int i = 0; i < 6; i++)  cycle(1'b0, 8'h81, 8'h00);

        // Owner 3 ends its tenure with LAST on the second beat.
        cycle(1'b0, 8'h00, 8'h00);
        cycle(1'b0, 8'h00, 8'h00);
        cycle(1'b0, 8'h08, 8'h00);
        cycle(1'b0, 8'h08, 8'h00);
        cycle(1'b0, 8'h08, 8'h08);
        check("last_gnt",   32'(GNT),   32'h0);
        check("last_valid", 32'(VALID), 32'h0);
        check("last_busy",  32'(BUSY),  32'h0);
        check("last_y",     Y,          32'd0);

        // Reset in the middle of owner 5's tenure.
        cycle(1'b0, 8'h20, 8'h00);
        cycle(1'b0, 8'h20, 8'h00);
        cycle(1'b0, 8'h20, 8'h00);
        cycle(1'b1, 8'h20, 8'h00);
        check("midrst_gnt", 32'(GNT), 32'h0);
        check("midrst_sel", 32'(SEL), 32'h0);
        cycle(1'b0, 8'h21, 8'h00);
        check("midrst_regrant", 32'(GNT), 32'h01);

        // Owner 2 drops its request while 6 waits.
        cycle(1'b0, 8'h00, 8'h00);
        cycle(1'b0, 8'h04, 8'h00);
        cycle(1'b0, 8'h40, 8'h00);
        check("handoff_gnt", 32'(GNT), 32'h40);
        check("handoff_sel", 32'(SEL), 32'h6);
        check("handoff_y",   Y,        32'd1431655706);

        // Random traffic with sparse LAST and occasional reset.
        for (int i = 0; i < 600; i++) begin
            logic       r;
            logic [7:0] q;
            logic [7:0] l;
            r = ($urandom_range(0, 63) == 0);
            q = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (8'($urandom) & 8'($urandom));
            l = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            cycle(r, q, l);
            if ($urandom_range(0, 3) == 0) data[$urandom_range(0, 7)] = $urandom;
        end

        cycle(1'b0, 8'h00, 8'h00);
        cycle(1'b0, 8'h00, 8'h00);
        @(negedge CLK);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
